expr_stream_checker: RTL and testbench

- Byte-serial checker for arithmetic expressions. Accepts one ASCII character per valid cycle.
- Reports whether the prefix received so far is a complete, well-formed expression.
- Supports multi-digit operands, four binary operators and nested parentheses up to a configurable depth.
- Sits after the character input stage; feeds status/LED logic and the expression-counter block.

---
 rtl/expr_pkg.sv | 35 +++
 rtl/expr_stream_checker_if.sv | 43 ++++
 rtl/expr_char_class.sv | 29 ++
 rtl/expr_stream_checker.sv | 164 ++++++++++++++++
 tb/tb_expr_stream_checker.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/expr_pkg.sv
// Shared types and constants for the expression-stream checker and future tokenizer blocks.
// Contents:
//   state_e       checker FSM states
//   char_class_e  character classes produced by expr_char_class
//   ASCII_*       character codes the classifier recognises
package expr_pkg;

  typedef enum logic [2:0] {
    S_START,
    S_OP,
    S_NUM,
    S_CLOSE,
    S_ERR
  } state_e;

  typedef enum logic [2:0] {
    C_DIGIT,
    C_OP,
    C_LP,
    C_RP,
    C_SEMI,
    C_OTHER
  } char_class_e;

  localparam logic [7:0] ASCII_ZERO   = 8'h30;  // '0'
  localparam logic [7:0] ASCII_NINE   = 8'h39;  // '9'
  localparam logic [7:0] ASCII_PLUS   = 8'h2B;  // '+'
  localparam logic [7:0] ASCII_MINUS  = 8'h2D;  // '-'
  localparam logic [7:0] ASCII_STAR   = 8'h2A;  // '*'
  localparam logic [7:0] ASCII_SLASH  = 8'h2F;  // '/'
  localparam logic [7:0] ASCII_LPAREN = 8'h28;  // '('
  localparam logic [7:0] ASCII_RPAREN = 8'h29;  // ')'
  localparam logic [7:0] ASCII_SEMI   = 8'h3B;  // ';'

endpackage

// File: rtl/expr_stream_checker_if.sv
// Character stream and status bundle between the character input stage and the checker.
// Parameter:
//   DEPTH_W   width of the nesting-depth status field
// Signals:
//   in_valid  in carries a character this cycle
//   in        ASCII character
//   out       accepted prefix is a complete valid expression
//   err       sticky syntax error flag
//   depth     current open-parenthesis count
//   done      one-cycle pulse when an expression is terminated by ';'
// Modports:
//   master    character source / status consumer
//   slave     the checker
interface expr_stream_checker_if #(
  parameter int unsigned DEPTH_W = 3
);

  logic               in_valid;
  logic [7:0]         in;
  logic               out;
  logic               err;
  logic [DEPTH_W-1:0] depth;
  logic               done;

  modport master (
    output in_valid,
    output in,
    input  out,
    input  err,
    input  depth,
    input  done
  );

  modport slave (
    input  in_valid,
    input  in,
    output out,
    output err,
    output depth,
    output done
  );

endinterface

// File: rtl/expr_char_class.sv
// Purely combinational ASCII character classifier.
// Ports:
//   in   8-bit ASCII character
//   cls  character class (digit, operator, '(', ')', ';', other)
// ';' is always reported as C_SEMI here; whether a terminator is meaningful is up to the
// consumer.
module expr_char_class
  import expr_pkg::*;
(
  input  logic [7:0]  in,
  output char_class_e cls
);

  always_comb begin
    cls = C_OTHER;
    if ((in >= ASCII_ZERO) && (in <= ASCII_NINE)) begin
      cls = C_DIGIT;
    end else begin
      case (in)
        ASCII_PLUS, ASCII_MINUS, ASCII_STAR, ASCII_SLASH: cls = C_OP;
        ASCII_LPAREN: cls = C_LP;
        ASCII_RPAREN: cls = C_RP;
        ASCII_SEMI:   cls = C_SEMI;
        default:      cls = C_OTHER;
      endcase
    end
  end

endmodule

// File: rtl/expr_stream_checker.sv
// Byte-serial arithmetic expression checker. One ASCII character is accepted per valid cycle;
// the registered status reports whether the prefix seen so far is a complete, well-formed
// expression (multi-digit operands, + - * /, nested parentheses).
// Parameters:
//   MAX_DIGITS  maximum digits per operand (1..15)
//   MAX_DEPTH   maximum parenthesis nesting depth (1..255)
//   DEPTH_W     derived width of the depth output
// Ports:
//   clk   clock, rising edge
//   clr   asynchronous active-high reset
//   bus   slave side of expr_stream_checker_if (in_valid/in in, out/err/depth/done out)
// Build option:
//   EXPR_SEMI_RESTART_EN  when defined, ';' after a complete expression pulses done and
//                         restarts the checker; otherwise ';' is an error and done is tied 0.
module expr_stream_checker
  import expr_pkg::*;
#(
  parameter int unsigned MAX_DIGITS = 4,
  parameter int unsigned MAX_DEPTH  = 7,
  localparam int unsigned DEPTH_W   = $clog2(MAX_DEPTH + 1)
) (
  input logic                  clk,
  input logic                  clr,
  expr_stream_checker_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(MAX_DIGITS + 1);
  localparam logic [DEPTH_W-1:0] DEPTH_LIMIT = DEPTH_W'(MAX_DEPTH);
  localparam logic [CNT_W-1:0]   CNT_LIMIT   = CNT_W'(MAX_DIGITS);

  char_class_e        cls;
  state_e             state_q, state_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               out_q, out_d;
  logic               err_q;

  expr_char_class u_char_class (
    .in  (bus.in),
    .cls (cls)
  );

`ifdef EXPR_SEMI_RESTART_EN
  logic done_q, done_d;
`endif

  always_comb begin
    state_d = state_q;
    depth_d = depth_q;
    cnt_d   = cnt_q;
`ifdef EXPR_SEMI_RESTART_EN
    done_d  = 1'b0;
`endif
    if (bus.in_valid) begin
      unique case (state_q)
        S_START, S_OP: begin
          case (cls)
            C_DIGIT: begin
              state_d = S_NUM;
              cnt_d   = CNT_W'(1);
            end
            C_LP: begin
              if (depth_q < DEPTH_LIMIT) depth_d = depth_q + DEPTH_W'(1);
              else                       state_d = S_ERR;
            end
            default: state_d = S_ERR;
          endcase
        end
        S_NUM: begin
          case (cls)
            C_DIGIT: begin
              if (cnt_q < CNT_LIMIT) cnt_d   = cnt_q + CNT_W'(1);
              else                   state_d = S_ERR;
            end
            C_OP: begin
              state_d = S_OP;
              cnt_d   = '0;
            end
            C_RP: begin
              if (depth_q != '0) begin
                state_d = S_CLOSE;
                depth_d = depth_q - DEPTH_W'(1);
              end else begin
                state_d = S_ERR;
              end
            end
`ifdef EXPR_SEMI_RESTART_EN
            C_SEMI: begin
              // out_q already encodes "complete expression at depth 0"
              if (out_q) begin
                state_d = S_START;
                depth_d = '0;
                cnt_d   = '0;
                done_d  = 1'b1;
              end else begin
                state_d = S_ERR;
              end
            end
`endif
            default: state_d = S_ERR;
          endcase
        end
        S_CLOSE: begin
          case (cls)
            C_OP: state_d = S_OP;
            C_RP: begin
              if (depth_q != '0) depth_d = depth_q - DEPTH_W'(1);
              else               state_d = S_ERR;
            end
`ifdef EXPR_SEMI_RESTART_EN
            C_SEMI: begin
              if (out_q) begin
                state_d = S_START;
                depth_d = '0;
                cnt_d   = '0;
                done_d  = 1'b1;
              end else begin
                state_d = S_ERR;
              end
            end
`endif
            default: state_d = S_ERR;
          endcase
        end
        S_ERR: state_d = S_ERR;
        default: state_d = S_ERR;
      endcase
    end
    // When idle the next state equals the current one, so out simply holds.
    out_d = ((state_d == S_NUM) || (state_d == S_CLOSE)) && (depth_d == '0);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= S_START;
      depth_q <= '0;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      err_q   <= 1'b0;
`ifdef EXPR_SEMI_RESTART_EN
      done_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      err_q   <= (state_d == S_ERR);
`ifdef EXPR_SEMI_RESTART_EN
      done_q  <= done_d;
`endif
    end
  end

  assign bus.out   = out_q;
  assign bus.err   = err_q;
  assign bus.depth = depth_q;
`ifdef EXPR_SEMI_RESTART_EN
  assign bus.done  = done_q;
`else
  assign bus.done  = 1'b0;
`endif

endmodule

// File: tb/tb_expr_stream_checker.sv
module tb_expr_stream_checker;

  localparam int unsigned MAX_DIGITS = 4;
  localparam int unsigned MAX_DEPTH  = 2;
  localparam int unsigned DW         = $clog2(MAX_DEPTH + 1);
`ifdef EXPR_SEMI_RESTART_EN
  localparam bit SEMI_EN = 1'b1;
`else
  localparam bit SEMI_EN = 1'b0;
`endif

  logic clk;
  logic clr;

  expr_stream_checker_if #(.DEPTH_W(DW)) bus ();

  expr_stream_checker #(
    .MAX_DIGITS (MAX_DIGITS),
    .MAX_DEPTH  (MAX_DEPTH)
  ) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit out;
    bit err;
    bit done;
    int depth;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: judged from the last accepted character and simple counters.
  logic [7:0] m_last;
  int         m_run;
  int         m_depth;
  bit         m_err;
  bit         m_done;

  function automatic bit is_dig(input logic [7:0] c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction

  function automatic bit m_ends();
    return is_dig(m_last) || (m_last == 8'h29);
  endfunction

  function automatic void model_reset();
    m_last  = 8'h00;
    m_run   = 0;
    m_depth = 0;
    m_err   = 1'b0;
    m_done  = 1'b0;
  endfunction

  function automatic void model_step(input bit v, input logic [7:0] c);
    bit ok   = 1'b0;
    bit semi = 1'b0;
    int nrun = m_run;
    int ndep = m_depth;
    m_done = 1'b0;
    if (v && !m_err) begin
      if (is_dig(c)) begin
        if (is_dig(m_last)) begin
          ok   = m_run < MAX_DIGITS;
          nrun = m_run + 1;
        end else begin
          ok   = (m_last != 8'h29);
          nrun = 1;
        end
      end else if (c == 8'h2B || c == 8'h2D || c == 8'h2A || c == 8'h2F) begin
        ok = m_ends();
      end else if (c == 8'h28) begin
        ok   = !m_ends() && (m_depth < MAX_DEPTH);
        ndep = m_depth + 1;
      end else if (c == 8'h29) begin
        ok   = m_ends() && (m_depth > 0);
        ndep = m_depth - 1;
      end else if (c == 8'h3B && SEMI_EN) begin
        ok   = m_ends() && (m_depth == 0);
        semi = 1'b1;
      end
      if (!ok) begin
        m_err = 1'b1;
      end else if (semi) begin
        m_done  = 1'b1;
        m_last  = 8'h00;
        m_run   = 0;
        m_depth = 0;
      end else begin
        m_last  = c;
        m_run   = nrun;
        m_depth = ndep;
      end
    end
  endfunction

  function automatic exp_t model_expect();
    exp_t e;
    e.out   = !m_err && m_ends() && (m_depth == 0);
    e.err   = m_err;
    e.done  = m_done;
    e.depth = m_depth;
    return e;
  endfunction

  function automatic void check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endfunction

  // Monitor: every accepted cycle has one expectation queued ahead of its edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("out",   int'(bus.out),   int'(e.out));
        check("err",   int'(bus.err),   int'(e.err));
        check("done",  int'(bus.done),  int'(e.done));
        check("depth", int'(bus.depth), e.depth);
      end
    end
  end

  task automatic step(input bit v, input logic [7:0] c);
    @(negedge clk);
    bus.in_valid = v;
    bus.in       = c;
    model_step(v, c);
    exp_q.push_back(model_expect());
  endtask

  task automatic drain();
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
      #2;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // clr is raised between edges; outputs must clear without waiting for a clock.
  task automatic do_reset();
    drain();
    @(posedge clk);
    #3;
    clr = 1'b1;
    #1;
    check("rst_out",   int'(bus.out),   0);
    check("rst_err",   int'(bus.err),   0);
    check("rst_depth", int'(bus.depth), 0);
    check("rst_done",  int'(bus.done),  0);
    model_reset();
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic run_str(input string s, input bit fo, input bit fe, input int fd);
    for (int i = 0; i < s.len(); i++) step(1'b1, s[i]);
    drain();
    check({"end_out ", s},   int'(bus.out),   int'(fo));
    check({"end_err ", s},   int'(bus.err),   int'(fe));
    check({"end_depth ", s}, int'(bus.depth), fd);
  endtask

  task automatic random_seq(input int len);
    string legal;
    string any_c = "0123456789+-*/();x ";
    logic [7:0] c;
    for (int i = 0; i < len; i++) begin
      if ($urandom_range(0, 5) == 0) step(1'b0, 8'($urandom));
      if (!m_err && $urandom_range(0, 9) < 8) begin
        if (m_ends()) begin
          legal = ")+-*/";
          if (is_dig(m_last)) legal = {legal, "0123456789"};
          if (SEMI_EN && m_depth == 0) legal = {legal, ";"};
        end else begin
          legal = "0123456789((";
        end
        c = legal[$urandom_range(0, legal.len() - 1)];
      end else begin
        c = any_c[$urandom_range(0, any_c.len() - 1)];
      end
      step(1'b1, c);
    end
  endtask

  initial begin
    clr          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in       = 8'h00;
    model_reset();
    #12;
    check("init_out",   int'(bus.out),   0);
    check("init_err",   int'(bus.err),   0);
    check("init_depth", int'(bus.depth), 0);
    @(negedge clk);
    clr = 1'b0;

    run_str("12+3", 1'b1, 1'b0, 0);
    do_reset();
    run_str("(1*(2-3))", 1'b1, 1'b0, 0);
    do_reset();
    run_str("12345", 1'b0, 1'b1, 0);
    do_reset();
    run_str("1234", 1'b1, 1'b0, 0);
    do_reset();
    run_str("007", 1'b1, 1'b0, 0);
    do_reset();
    run_str("(((", 1'b0, 1'b1, 2);
    do_reset();
    run_str(")", 1'b0, 1'b1, 0);
    do_reset();
    run_str("1)", 1'b0, 1'b1, 0);
    do_reset();
    run_str("(1)2", 1'b0, 1'b1, 0);
    do_reset();
    run_str("-1", 1'b0, 1'b1, 0);
    do_reset();
    run_str("1;", 1'b0, !SEMI_EN, 0);
    do_reset();

    // Hold with garbage on the bus, then clear mid-expression.
    run_str("(12", 1'b0, 1'b0, 1);
    for (int i = 0; i < 5; i++) step(1'b0, 8'($urandom));
    drain();
    check("hold_depth", int'(bus.depth), 1);
    do_reset();
    run_str("1+", 1'b0, 1'b0, 0);
    for (int i = 0; i < 5; i++) step(1'b0, 8'($urandom));
    do_reset();
    run_str("7", 1'b1, 1'b0, 0);
    do_reset();

`ifdef EXPR_SEMI_RESTART_EN
    run_str("3*4;5", 1'b1, 1'b0, 0);
    do_reset();
    run_str("3*;", 1'b0, 1'b1, 0);
    do_reset();
`endif

    for (int n = 0; n < 40; n++) begin
      random_seq($urandom_range(1, 30));
      do_reset();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
